// File: rtl/sw_lut_pkg.sv
// Shared constants and sizing helpers for the switch-to-LED truth-table evaluator.
package sw_lut_pkg;

  // Mode encoding; the reserved code behaves as level.
  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_LATCH  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  function automatic int tbl_w(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce
  import sw_lut_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic db
);

  localparam int CW = clog2_min1(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Any return of s2 to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sw_lut_eval.sv
// Per-channel debounced switch slice looked up in a loadable truth table,
// driving an LED in level, latch or toggle mode.
module sw_lut_eval
  import sw_lut_pkg::*;
#(
  parameter int                                NUM_CH     = 3,
  parameter int                                SEL_W      = 4,
  parameter int                                DEB_CYCLES = 4,
  parameter logic [NUM_CH*(2**SEL_W)-1:0]      LUT_INIT   = {NUM_CH{16'h6996}},
  parameter logic [2*NUM_CH-1:0]               MODE_INIT  = {NUM_CH{2'b00}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*SEL_W-1:0]        sw,
  input  logic                           lut_we,
  input  logic [clog2_min1(NUM_CH)-1:0]  lut_ch,
  input  logic [tbl_w(SEL_W)-1:0]        lut_data,
  input  logic [1:0]                     lut_mode,
  input  logic                           clr,
  output logic [NUM_CH-1:0]              led,
  output logic [NUM_CH-1:0]              chg,
  output logic                           lut_err
);

  localparam int TW  = tbl_w(SEL_W);
  localparam int NSW = NUM_CH * SEL_W;

  logic [NSW-1:0]    db;
  logic [TW-1:0]     lut  [NUM_CH];
  mode_e             mode [NUM_CH];
  logic [NUM_CH-1:0] f;
  logic [NUM_CH-1:0] f_q;
  logic [NUM_CH-1:0] led_next;
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_ok;

  for (genvar i = 0; i < NSW; i++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw[i]),
      .db   (db[i])
    );
  end

  // lut_we is a single-cycle strobe with no back-pressure: it is always
  // accepted, and a channel index out of range only raises lut_err.
  always_comb begin
    wr_ok  = lut_we && (int'(lut_ch) < NUM_CH);
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = wr_ok && (int'(lut_ch) == c);
    end
  end

  always_comb begin
    f = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      f[c] = lut[c][db[c*SEL_W +: SEL_W]];
    end
  end

  // A write's clear outranks everything; clr only touches stateful modes.
  always_comb begin
    led_next = led;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit[c]) begin
        led_next[c] = 1'b0;
      end else begin
        case (mode[c])
          MODE_LATCH:  led_next[c] = clr ? 1'b0 : (led[c] | f[c]);
          MODE_TOGGLE: led_next[c] = clr ? 1'b0 : (led[c] ^ (f[c] & ~f_q[c]));
          default:     led_next[c] = f[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lut[c]  <= LUT_INIT[c*TW +: TW];
        mode[c] <= mode_e'(MODE_INIT[2*c +: 2]);
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_hit[c]) begin
          lut[c]  <= lut_data;
          mode[c] <= mode_e'(lut_mode);
        end
      end
    end
  end

  // f_q resets high so a channel already at 1 does not toggle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '1;
      led     <= '0;
      chg     <= '0;
      lut_err <= 1'b0;
    end else begin
      f_q     <= f;
      led     <= led_next;
      chg     <= led_next ^ led;
      lut_err <= lut_we && !wr_ok;
    end
  end

endmodule

// File: tb/tb_sw_lut_eval.sv
// Randomised and directed bench for sw_lut_eval against a window-based reference model.
module tb_sw_lut_eval;

  localparam int NUM_CH = 3;
  localparam int SEL_W  = 4;
  localparam int DEB    = 4;
  localparam int TW     = 16;
  localparam int SWW    = NUM_CH * SEL_W;
  localparam int CHW    = 2;
  localparam logic [NUM_CH*TW-1:0] LUT_INIT  = {NUM_CH{16'h6996}};
  localparam logic [2*NUM_CH-1:0]  MODE_INIT = '0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SWW-1:0]    sw;
  logic              lut_we;
  logic [CHW-1:0]    lut_ch;
  logic [TW-1:0]     lut_data;
  logic [1:0]        lut_mode;
  logic              clr;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] chg;
  logic              lut_err;

  always #5 clk = ~clk;

  sw_lut_eval #(
    .NUM_CH    (NUM_CH),
    .SEL_W     (SEL_W),
    .DEB_CYCLES(DEB),
    .LUT_INIT  (LUT_INIT),
    .MODE_INIT (MODE_INIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .lut_we  (lut_we),
    .lut_ch  (lut_ch),
    .lut_data(lut_data),
    .lut_mode(lut_mode),
    .clr     (clr),
    .led     (led),
    .chg     (chg),
    .lut_err (lut_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a switch level is accepted once the synchronised value
  // has disagreed with the accepted level for the last DEB edges in a row.
  logic [SWW-1:0]    s1m, s2m, dbm;
  logic [SWW-1:0]    win [$];
  logic [TW-1:0]     lutm [NUM_CH];
  logic [1:0]        modem [NUM_CH];
  logic [NUM_CH-1:0] fqm, ledm, chgm, fm, lnm;
  logic              errm;
  bit                all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1m = '0;
      s2m = '0;
      dbm = '0;
      win.delete();
      fqm = '1;
      ledm = '0;
      chgm = '0;
      errm = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        lutm[c]  = LUT_INIT[c*TW +: TW];
        modem[c] = MODE_INIT[2*c +: 2];
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) fm[c] = lutm[c][dbm[c*SEL_W +: SEL_W]];
      for (int c = 0; c < NUM_CH; c++) begin
        if (lut_we && lut_ch == c)  lnm[c] = 1'b0;
        else if (modem[c] == 2'b01) lnm[c] = clr ? 1'b0 : (ledm[c] | fm[c]);
        else if (modem[c] == 2'b10) lnm[c] = clr ? 1'b0 : (ledm[c] ^ (fm[c] & ~fqm[c]));
        else                        lnm[c] = fm[c];
      end
      chgm = lnm ^ ledm;
      ledm = lnm;
      errm = lut_we && (lut_ch >= NUM_CH);
      fqm  = fm;
      if (lut_we && lut_ch < NUM_CH) begin
        lutm[lut_ch]  = lut_data;
        modem[lut_ch] = lut_mode;
      end
      win.push_back(s2m);
      if (win.size() > DEB) void'(win.pop_front());
      if (win.size() == DEB) begin
        for (int b = 0; b < SWW; b++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][b] == dbm[b]) all_diff = 1'b0;
          if (all_diff) dbm[b] = ~dbm[b];
        end
      end
      s2m = s1m;
      s1m = sw;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) if (chg[c]) chg_cnt[c]++;
    check("led", 32'(led), 32'(ledm));
    check("chg", 32'(chg), 32'(chgm));
    check("lut_err", 32'(lut_err), 32'(errm));
  endtask

  task automatic write(input int ch, input logic [TW-1:0] d, input logic [1:0] m);
    lut_we   = 1'b1;
    lut_ch   = CHW'(ch);
    lut_data = d;
    lut_mode = m;
    cyc();
    lut_we   = 1'b0;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) chg_cnt[c] = 0;
  endtask

  initial begin
    sw = '0; lut_we = 1'b0; lut_ch = '0; lut_data = '0; lut_mode = '0; clr = 1'b0;
    clear_counts();
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_chg", 32'(chg), 32'h0);
    check("rst_err", 32'(lut_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // Single switch change reaches the LED six edges after the first sample.
    sw = 12'h001;
    repeat (6) cyc();
    check("t1_before", 32'(led), 32'h0);
    cyc();
    check("t1_led", 32'(led), 32'h1);
    check("t1_chg", 32'(chg), 32'h1);
    cyc();
    check("t1_chg_end", 32'(chg), 32'h0);

    // Bounce shorter than the debounce window is ignored.
    sw = '0;
    repeat (10) cyc();
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      repeat (2) cyc();
    end
    repeat (10) cyc();
    check("t2_led", 32'(led), 32'h0);
    check("t2_chg_cnt", 32'(chg_cnt[0]), 32'h0);

    // Toggle mode on channel 1.
    write(1, 16'h0008, 2'b10);
    clear_counts();
    sw = 12'h030; repeat (10) cyc();
    check("t3_set", 32'(led[1]), 32'h1);
    sw = 12'h000; repeat (10) cyc();
    check("t3_hold", 32'(led[1]), 32'h1);
    sw = 12'h030; repeat (10) cyc();
    check("t3_off", 32'(led[1]), 32'h0);
    check("t3_pulses", 32'(chg_cnt[1]), 32'h2);

    // Latch mode on channel 2 with clr priority.
    write(2, 16'h8000, 2'b01);
    sw = 12'hF30; repeat (10) cyc();
    check("t4_set", 32'(led[2]), 32'h1);
    sw = 12'h030; repeat (10) cyc();
    check("t4_hold", 32'(led[2]), 32'h1);
    sw = 12'hF30; repeat (10) cyc();
    clr = 1'b1; cyc();
    check("t4_clr", 32'(led[2]), 32'h0);
    clr = 1'b0; cyc();
    check("t4_reset", 32'(led[2]), 32'h1);

    // Write to a nonexistent channel.
    write(3, 16'hFFFF, 2'b10);
    check("t5_err", 32'(lut_err), 32'h1);
    cyc();
    check("t5_err_end", 32'(lut_err), 32'h0);
    check("t5_led", 32'(led), 32'h4);

    // Reset in the middle of a debounce.
    sw = 12'h0FF;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    check("t6_led", 32'(led), 32'h0);
    check("t6_chg", 32'(chg), 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    check("t6_after", 32'(led), 32'h0);
    sw = 12'h8FF; repeat (10) cyc();
    check("t6_tbl", 32'(led), 32'h4);

    // Randomised traffic, including a mid-run reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) sw = sw ^ (SWW'(1) << $urandom_range(0, SWW - 1));
      if ($urandom_range(0, 60) == 0) sw = SWW'($urandom);
      lut_we   = ($urandom_range(0, 15) == 0);
      lut_ch   = CHW'($urandom_range(0, 3));
      lut_data = TW'($urandom);
      lut_mode = 2'($urandom_range(0, 3));
      clr      = ($urandom_range(0, 15) == 0);
      if (i == 400) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst_led", 32'(led), 32'h0);
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    lut_we = 1'b0; clr = 1'b0;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sw_lut_eval.md
# sw_lut_eval

Parametrised switch-to-LED logic evaluator for the Basys3 examples. Each of NUM_CH channels takes a contiguous SEL_W-bit slice of the board switches, passes every bit through a synchroniser and debouncer, and looks the debounced slice up in a runtime-loadable truth table. The channel's LED then follows the result in level, latch or toggle mode. It sits between the raw `sw` pins and the `led` pins, replacing hand-written per-LED sum-of-products logic.

## Interface
Parameters:
- NUM_CH, 3: number of channels / LEDs.
- SEL_W, 4: switch bits per channel; table depth 2^SEL_W.
- DEB_CYCLES, 4: consecutive stable cycles required to accept a switch change; must be at least 1.
- LUT_INIT, {NUM_CH{16'h6996}}: reset truth tables, NUM_CH*2^SEL_W bits; channel c occupies bits [c*2^SEL_W +: 2^SEL_W].
- MODE_INIT, {NUM_CH{2'b00}}: reset modes, 2 bits per channel.

Ports:
- clk, input, 1: single clock; all state on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- sw, input, NUM_CH*SEL_W: raw asynchronous switches; channel c reads sw[c*SEL_W +: SEL_W].
- lut_we, input, 1: write strobe for one channel's table and mode.
- lut_ch, input, clog2(NUM_CH) (minimum 1): target channel.
- lut_data, input, 2^SEL_W: new truth table; bit i is the output for slice value i.
- lut_mode, input, 2: new mode (00 level, 01 latch, 10 toggle, 11 reserved = level).
- clr, input, 1: clears latch/toggle LEDs.
- led, output, NUM_CH: registered LED outputs.
- chg, output, NUM_CH: one-cycle pulse coinciding with each led[c] change.
- lut_err, output, 1: one-cycle pulse after a write to a nonexistent channel.

## Operation
- Sync: two flops per switch (s1, s2), both reset to 0.
- Debounce, per switch:
  - db (reset 0) and cnt (reset 0, width clog2(DEB_CYCLES+1)).
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of s2 to db restarts the count.
- Lookup: f[c] = lut[c][db slice], combinational. f_q[c] registers f[c] every cycle and resets to 1, so no toggle occurs at the first cycle after reset.
- Per-channel LED update, highest priority first:
  1. A write to this channel: led <= 0.
  2. Level mode: led <= f.
  3. clr (latch or toggle mode only): led <= 0.
  4. Latch mode: led <= led | f.
  5. Toggle mode: led <= led ^ (f & ~f_q).
- chg <= led_next ^ led.
- Table writes:
  - lut_we with lut_ch < NUM_CH loads that channel's lut and mode at the edge. The new table is used from the following cycle.
  - A rising f caused by a table rewrite counts as an edge in toggle mode.
  - lut_we with lut_ch >= NUM_CH changes no state; lut_err <= 1 for one cycle.
- Reset values: led 0, chg 0, lut_err 0, lut = LUT_INIT, mode = MODE_INIT.
- Reset mid-debounce discards any pending change.

## Timing
- Switch-to-LED latency, for a switch change stable before edge 0:
  - Edge 1: s2 updates.
  - Edge DEB_CYCLES+1: db updates.
  - Edge DEB_CYCLES+2: led and chg update.
- Write-to-LED:
  - Write at edge N: led 0 at edge N.
  - Edge N+1: led = new-table f (level) or 0/set (latch/toggle).
- lut_err appears the edge after the bad write, for exactly one cycle.
- clr acts at the edge it is sampled; it has no effect on level-mode channels.
- Simultaneous clr and toggle/latch set: clr wins.
- Simultaneous write and clr: the write's clear applies to that channel; clr applies to the others.

## Structure
- Package sw_lut_pkg:
  - mode constants MODE_LEVEL, MODE_LATCH, MODE_TOGGLE.
  - function returning table width 2^SEL_W.
  - clog2-with-minimum-1 helper.
- Sub-module sw_debounce: one switch bit; holds the synchroniser, counter and db. Instantiated NUM_CH*SEL_W times via generate.
- Tables, modes and LED state stay in the top.

## Test plan
1. Defaults (parity tables, DEB_CYCLES=4), sw=0x000, then sw=0x001 held -> led=3'b001 after edge 6 counting from the change; chg[0] high for one cycle; led[2:1] stay 0.
2. Bounce: sw[0] toggled every 2 cycles for 20 cycles, then returned to 0 -> led and chg never change.
3. Write ch1 lut=16'h0008, mode toggle. sw[7:4]=0x3 (db 3 -> 16'h0008 bit 3 = 1, f[1] rises) -> led[1]=1. Return sw[7:4] to 0 -> led[1] holds 1. Set 0x3 again -> led[1]=0. Expect two chg[1] pulses.
4. Write ch2 latch, lut=16'h8000. sw[11:8]=0xF -> led[2]=1. sw back to 0 -> led[2] holds. Assert clr while sw=0xF -> led[2]=0 that edge, then 1 at the next edge.
5. lut_we with lut_ch=3 (NUM_CH=3) -> lut_err single pulse; all tables, modes and led unchanged.
6. Start changing sw=0x0FF, deassert rst_n after 2 cycles of debounce -> led=0 and tables at LUT_INIT immediately. After release, the held switches propagate with full latency.
